seque_gen: RTL and testbench
============================

SEQUE_GEN -- requirements
Module: seque_gen

Interface
REQ-001 Parameter WIDTH, default 16: maximum pattern length in bits.
REQ-002 Parameter GAP, default 0: number of idle cycles (out=0, valid=0) inserted between repetitions.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port start  input  1  request to begin a transmission; sampled only in IDLE.
REQ-006 Port stop  input  1  abort request; honoured in any non-IDLE state.
REQ-007 Port pattern  input  WIDTH  bit pattern to transmit, right-justified; bit len-1 is sent first.
REQ-008 Port len  input  clog2(WIDTH+1)  number of pattern bits, valid range 1..WIDTH.
REQ-009 Port rpt  input  8  extra repetitions; total transmissions = rpt+1.
REQ-010 Port out  output  1  serial bit stream, feeds a sequence detector's `in` port.
REQ-011 Port valid  output  1  high while out carries a pattern bit.
REQ-012 Port frame  output  1  high on the first bit of every repetition.
REQ-013 Port busy  output  1  high in every state except IDLE.
REQ-014 Port done  output  1  one-cycle pulse after normal completion.
REQ-015 Port err  output  1  one-cycle pulse on a rejected start.

Function
REQ-016 The block SHALL implement the states IDLE, SHIFT, GAP and DONE.
REQ-017 In IDLE, a start with 1<=len<=WIDTH SHALL capture pattern, len and rpt into internal registers and enter SHIFT on the next edge.
REQ-018 In IDLE, a start with len=0 or len>WIDTH SHALL stay in IDLE and pulse err for exactly one cycle; no bit is emitted.
REQ-019 Latency: the first bit, pattern[len-1], SHALL appear on out with valid=1 and frame=1 in the cycle immediately after the accepted start cycle.
REQ-020 SHIFT SHALL emit one bit per cycle, MSB-first from captured bit len-1 down to bit 0, with valid=1 each cycle.
REQ-021 Changes on the pattern, len or rpt inputs after capture SHALL NOT affect the transmission in progress.
REQ-022 After bit 0, with repetitions remaining: if GAP=0, the next cycle SHALL emit bit len-1 again with frame=1 (back-to-back); if GAP>0, the block SHALL enter GAP for exactly GAP cycles, then SHIFT.
REQ-023 The repetition counter SHALL decrement once per completed repetition and SHALL NOT wrap; rpt=255 SHALL yield exactly 256 transmissions.
REQ-024 After bit 0 of the final repetition, the block SHALL enter DONE for one cycle with done=1, valid=0, out=0 and busy=1, then return to IDLE.
REQ-025 start asserted while busy=1 SHALL be ignored, including in the DONE cycle; err SHALL NOT pulse.
REQ-026 stop in SHIFT, GAP or DONE SHALL return the block to IDLE on the next edge; in that next cycle out=0, valid=0, busy=0 and done=0.
REQ-027 If stop and start are asserted together in IDLE, start SHALL take effect and stop SHALL be ignored.
REQ-028 Whenever valid=0, out and frame SHALL both be 0.
REQ-029 len=1 SHALL emit a single bit per repetition, with frame=1 on every emitted bit.

Reset
REQ-030 When rst=1 at a clock edge, the block SHALL enter IDLE and clear all counters and captured registers; at that edge out=0, valid=0, frame=0, busy=0, done=0 and err=0.
REQ-031 rst SHALL take priority over start and stop, and mid-transmission it SHALL abort without a done pulse.

Verification
REQ-032 pattern=9'b111011011, len=9, rpt=0, start for 1 cycle -> cycles 1..9 out=1,1,1,0,1,1,0,1,1 with valid=1, frame=1 only in cycle 1; done=1 in cycle 10; busy=0 in cycle 11.
REQ-033 pattern=10'b1011011011, len=10, rpt=2, GAP=0 -> 30 consecutive valid bits, frame=1 at cycles 1, 11 and 21; a single done pulse in cycle 31.
REQ-034 Same stimulus as REQ-033 with GAP=2 -> 2 cycles with valid=0 between repetitions; done pulse in cycle 35.
REQ-035 start with len=0, then with len=WIDTH+1 -> err pulses for 1 cycle each; busy, valid and done stay 0.
REQ-036 stop asserted at bit 4 of a len=9 transmission -> IDLE in the next cycle with valid=0 and no done pulse; a start 1 cycle later is accepted normally. Repeat with rst=1 at bit 4 -> all outputs 0 at the reset edge.
REQ-037 Loopback: drive seque_detect with out, and use a detector-target pattern with rpt=3 -> the detector out asserts once per repetition at the expected cycle.

Source files
------------

// File: rtl/seque_gen_if.sv
`default_nettype none
// ============================================================================
// Interface : seque_gen_if
// Purpose   : control/pattern inputs and serial outputs of seque_gen
// Revision  : 1.0
// ============================================================================
interface seque_gen_if #(
   parameter int WIDTH = 16
) ();
   localparam int LW = $clog2(WIDTH + 1);

   logic             start;
   logic             stop;
   logic [WIDTH-1:0] pattern;
   logic [LW-1:0]    len;
   logic [7:0]       rpt;
   logic             out;
   logic             valid;
   logic             frame;
   logic             busy;
   logic             done;
   logic             err;

   modport master (
      output start, stop, pattern, len, rpt,
      input  out, valid, frame, busy, done, err
   );

   modport slave (
      input  start, stop, pattern, len, rpt,
      output out, valid, frame, busy, done, err
   );
endinterface
`default_nettype wire

// File: rtl/seque_gen.sv
`default_nettype none
// ============================================================================
// Module   : seque_gen
// Purpose  : serial bit-pattern generator with repeat count and inter-repeat gap
// Revision : 1.0
// ============================================================================
module seque_gen #(
   parameter int WIDTH = 16,
   parameter int GAP   = 0
) (
   input  wire logic  clk,
   input  wire logic  rst,
   seque_gen_if.slave bus
);
   localparam int LW = $clog2(WIDTH + 1);
   localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
   localparam logic [LW-1:0] C_WIDTH    = LW'(WIDTH);
   localparam logic [LW-1:0] C_ONE      = LW'(1);
   localparam logic [GW-1:0] C_GAP_LOAD = GW'((GAP > 0) ? GAP - 1 : 0);
   localparam logic [GW-1:0] C_GAP_ONE  = GW'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_GAP   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_pat;
   logic [WIDTH-1:0] r_sr;
   logic [LW-1:0]    r_len;
   logic [LW-1:0]    r_cnt;
   logic [7:0]       r_rpt;
   logic [GW-1:0]    r_gap;
   logic             r_out;
   logic             r_valid;
   logic             r_frame;
   logic             r_busy;
   logic             r_done;
   logic             r_err;

   logic             w_len_ok;
   logic [WIDTH-1:0] w_lj;

   // Pattern is left-justified at capture so the next bit is always the MSB.
   assign w_len_ok = (bus.len != '0) && (bus.len <= C_WIDTH);
   assign w_lj     = bus.pattern << (C_WIDTH - bus.len);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_pat   <= '0;
         r_sr    <= '0;
         r_len   <= '0;
         r_cnt   <= '0;
         r_rpt   <= '0;
         r_gap   <= '0;
         r_out   <= 1'b0;
         r_valid <= 1'b0;
         r_frame <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         if (r_state == S_IDLE) begin
            r_out   <= 1'b0;
            r_valid <= 1'b0;
            r_frame <= 1'b0;
            r_busy  <= 1'b0;
            if (bus.start) begin
               if (w_len_ok) begin
                  r_pat   <= w_lj;
                  r_len   <= bus.len;
                  r_rpt   <= bus.rpt;
                  r_out   <= w_lj[WIDTH-1];
                  r_sr    <= w_lj << 1;
                  r_cnt   <= bus.len - C_ONE;
                  r_valid <= 1'b1;
                  r_frame <= 1'b1;
                  r_busy  <= 1'b1;
                  r_state <= S_SHIFT;
               end else begin
                  r_err <= 1'b1;
               end
            end
         end else if (bus.stop) begin
            r_state <= S_IDLE;
            r_out   <= 1'b0;
            r_valid <= 1'b0;
            r_frame <= 1'b0;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               S_SHIFT: begin
                  if (r_cnt != '0) begin
                     r_out   <= r_sr[WIDTH-1];
                     r_sr    <= r_sr << 1;
                     r_cnt   <= r_cnt - C_ONE;
                     r_frame <= 1'b0;
                  end else if (r_rpt != 8'd0) begin
                     // Saturating count: zero means the final repetition just ended.
                     r_rpt <= r_rpt - 8'd1;
                     if (GAP == 0) begin
                        r_out   <= r_pat[WIDTH-1];
                        r_sr    <= r_pat << 1;
                        r_cnt   <= r_len - C_ONE;
                        r_valid <= 1'b1;
                        r_frame <= 1'b1;
                     end else begin
                        r_state <= S_GAP;
                        r_gap   <= C_GAP_LOAD;
                        r_out   <= 1'b0;
                        r_valid <= 1'b0;
                        r_frame <= 1'b0;
                     end
                  end else begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                     r_out   <= 1'b0;
                     r_valid <= 1'b0;
                     r_frame <= 1'b0;
                  end
               end
               S_GAP: begin
                  if (r_gap != '0) begin
                     r_gap <= r_gap - C_GAP_ONE;
                  end else begin
                     r_state <= S_SHIFT;
                     r_out   <= r_pat[WIDTH-1];
                     r_sr    <= r_pat << 1;
                     r_cnt   <= r_len - C_ONE;
                     r_valid <= 1'b1;
                     r_frame <= 1'b1;
                  end
               end
               S_DONE: begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
               default: begin
                  r_state <= S_IDLE;
                  r_out   <= 1'b0;
                  r_valid <= 1'b0;
                  r_frame <= 1'b0;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.out   = r_out;
   assign bus.valid = r_valid;
   assign bus.frame = r_frame;
   assign bus.busy  = r_busy;
   assign bus.done  = r_done;
   assign bus.err   = r_err;
endmodule
`default_nettype wire

// File: tb/tb_seque_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_seque_gen
// Purpose  : randomized self-checking bench for seque_gen (GAP=0 and GAP=2)
// Revision : 1.0
// ============================================================================
module tb_seque_gen;
   localparam int WIDTH = 16;
   localparam int LW    = $clog2(WIDTH + 1);

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   seque_gen_if #(.WIDTH(WIDTH)) bus0 ();
   seque_gen_if #(.WIDTH(WIDTH)) bus1 ();

   seque_gen #(.WIDTH(WIDTH), .GAP(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
   seque_gen #(.WIDTH(WIDTH), .GAP(2)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

   typedef struct packed {
      logic out;
      logic valid;
      logic frame;
      logic busy;
      logic done;
      logic err;
   } obs_t;

   obs_t sq[$];
   obs_t q0[$];
   obs_t q1[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc0 = 0;
   int   cyc1 = 0;
   int   fr0[$];
   int   dn0[$];
   int   dn1[$];
   int   det0[$];
   logic [3:0] win0 = '0;
   logic [3:0] vw0  = '0;

   // Expected cycle-by-cycle output sequence of one transaction, straight from the rules.
   task automatic build(input logic [WIDTH-1:0] pat, input int len, input int rpt, input int gap);
      obs_t e;
      sq.delete();
      if (len < 1 || len > WIDTH) begin
         e = '0; e.err = 1'b1; sq.push_back(e);
         return;
      end
      for (int r = 0; r <= rpt; r++) begin
         if (r > 0)
            for (int g = 0; g < gap; g++) begin
               e = '0; e.busy = 1'b1; sq.push_back(e);
            end
         for (int i = len - 1; i >= 0; i--) begin
            e = '0; e.out = pat[i]; e.valid = 1'b1; e.frame = (i == len - 1); e.busy = 1'b1;
            sq.push_back(e);
         end
      end
      e = '0; e.done = 1'b1; e.busy = 1'b1; sq.push_back(e);
   endtask

   function automatic int qsize(input int d);
      return (d == 0) ? q0.size() : q1.size();
   endfunction

   function automatic obs_t qfront(input int d);
      return (d == 0) ? q0[0] : q1[0];
   endfunction

   task automatic chk_int(input string nm, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   task automatic set_bus(input int d, input logic st, input logic sp, input logic [WIDTH-1:0] pat,
                          input logic [LW-1:0] ln, input logic [7:0] rp);
      if (d == 0) begin
         bus0.start = st; bus0.stop = sp; bus0.pattern = pat; bus0.len = ln; bus0.rpt = rp;
      end else begin
         bus1.start = st; bus1.stop = sp; bus1.pattern = pat; bus1.len = ln; bus1.rpt = rp;
      end
   endtask

   task automatic set_stop(input int d, input logic v);
      if (d == 0) bus0.stop = v; else bus1.stop = v;
   endtask

   task automatic set_start(input int d, input logic v);
      if (d == 0) bus0.start = v; else bus1.start = v;
   endtask

   // Called just after a rising edge; start is held for exactly one cycle.
   task automatic start_tx(input int d, input logic [WIDTH-1:0] pat, input int len, input int rpt, input logic sp);
      obs_t e;
      set_bus(d, 1'b1, sp, pat, LW'(len), 8'(rpt));
      build(pat, len, rpt, (d == 0) ? 0 : 2);
      e = '0;
      if (d == 0) begin
         q0.push_back(e); foreach (sq[i]) q0.push_back(sq[i]);
         cyc0 = -1; fr0.delete(); dn0.delete(); det0.delete();
      end else begin
         q1.push_back(e); foreach (sq[i]) q1.push_back(sq[i]);
         cyc1 = -1; dn1.delete();
      end
      @(posedge clk); #1;
      set_start(d, 1'b0);
      set_stop(d, 1'b0);
   endtask

   // Runs until the expected sequence is consumed; optionally scrambles inputs while busy.
   task automatic drain(input int d, input bit noise);
      int n = 0;
      while (qsize(d) != 0 && n < 6000) begin
         @(posedge clk); #1;
         n++;
         if (noise)
            set_bus(d, (qsize(d) != 0 && qfront(d).busy) ? ($urandom_range(0, 1) == 1) : 1'b0, 1'b0,
                    WIDTH'($urandom), LW'($urandom_range(0, WIDTH + 1)), 8'($urandom));
      end
      set_start(d, 1'b0);
      if (qsize(d) != 0) begin
         n_tests++; n_fail++;
         $display("FAIL drain_timeout dut%0d: %0d entries left, required 0", d, qsize(d));
         if (d == 0) q0.delete(); else q1.delete();
      end
   endtask

   task automatic abort_tx(input int d, input bit use_rst);
      start_tx(d, 16'h01DB, 9, 0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      if (use_rst) rst = 1'b1; else set_stop(d, 1'b1);
      if (d == 0) while (q0.size() > 1) void'(q0.pop_back());
      else        while (q1.size() > 1) void'(q1.pop_back());
      @(posedge clk); #1;
      rst = 1'b0;
      set_stop(d, 1'b0);
      chk_int(use_rst ? "abort_rst_no_done" : "abort_stop_no_done", (d == 0) ? dn0.size() : dn1.size(), 0);
      start_tx(d, 16'h0155, 9, 1, 1'b0);
      drain(d, 0);
      chk_int("after_abort_done", (d == 0) ? dn0.size() : dn1.size(), 1);
   endtask

   // Single compare process: both DUTs against the model on every falling edge.
   task automatic cmp(input int d, input obs_t a);
      obs_t e;
      int   c;
      e = '0;
      if (d == 0) begin
         if (q0.size() != 0) e = q0.pop_front();
         cyc0++; c = cyc0;
         if (a.frame) fr0.push_back(cyc0);
         if (a.done)  dn0.push_back(cyc0);
         win0 = {win0[2:0], a.out};
         vw0  = {vw0[2:0], a.valid};
         if (vw0 == 4'hF && win0 == 4'b1101) det0.push_back(cyc0);
      end else begin
         if (q1.size() != 0) e = q1.pop_front();
         cyc1++; c = cyc1;
         if (a.done) dn1.push_back(cyc1);
      end
      n_tests++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL dut%0d cycle %0d out/valid/frame/busy/done/err: got %b expected %b", d, c, a, e);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         cmp(0, obs_t'({bus0.out, bus0.valid, bus0.frame, bus0.busy, bus0.done, bus0.err}));
         cmp(1, obs_t'({bus1.out, bus1.valid, bus1.frame, bus1.busy, bus1.done, bus1.err}));
      end
   end

   initial begin
      logic [8:0] v9;
      int         nf;
      set_bus(0, 1'b0, 1'b0, '0, '0, '0);
      set_bus(1, 1'b0, 1'b0, '0, '0, '0);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Pin the model with hand-derived values.
      build(16'h01DB, 9, 0, 0);
      chk_int("model_len_9", sq.size(), 10);
      v9 = '0; nf = 0;
      for (int i = 0; i < 9; i++) begin v9[8-i] = sq[i].out; nf += int'(sq[i].frame); end
      chk_int("model_bits_9", int'(v9), 475);
      chk_int("model_frames_9", nf, 1);
      build(16'h02DB, 10, 2, 2);
      chk_int("model_len_gap2", sq.size(), 35);
      chk_int("model_done_gap2", int'(sq[34].done), 1);

      @(posedge clk); #1;
      start_tx(0, 16'h01DB, 9, 0, 1'b0);
      drain(0, 0);
      chk_int("basic9_done_count", dn0.size(), 1);
      if (dn0.size() == 1) chk_int("basic9_done_cycle", dn0[0], 10);

      @(posedge clk); #1;
      start_tx(0, 16'h02DB, 10, 2, 1'b0);
      drain(0, 0);
      chk_int("gap0_frame_count", fr0.size(), 3);
      if (fr0.size() == 3) begin
         chk_int("gap0_frame1", fr0[0], 1);
         chk_int("gap0_frame2", fr0[1], 11);
         chk_int("gap0_frame3", fr0[2], 21);
      end
      chk_int("gap0_done_count", dn0.size(), 1);
      if (dn0.size() == 1) chk_int("gap0_done_cycle", dn0[0], 31);

      @(posedge clk); #1;
      start_tx(1, 16'h02DB, 10, 2, 1'b0);
      drain(1, 0);
      chk_int("gap2_done_count", dn1.size(), 1);
      if (dn1.size() == 1) chk_int("gap2_done_cycle", dn1[0], 35);

      // Rejected starts.
      for (int d = 0; d < 2; d++) begin
         @(posedge clk); #1; start_tx(d, 16'hFFFF, 0, 0, 1'b0);         drain(d, 0);
         @(posedge clk); #1; start_tx(d, 16'hFFFF, WIDTH + 1, 0, 1'b0); drain(d, 0);
      end

      // Abort by stop and by reset, then restart right away.
      @(posedge clk); #1; abort_tx(0, 1'b0);
      @(posedge clk); #1; abort_tx(1, 1'b0);
      @(posedge clk); #1; abort_tx(0, 1'b1);

      // Simultaneous start and stop in IDLE; len=1 edge.
      @(posedge clk); #1; start_tx(1, 16'h00A5, 8, 1, 1'b1); drain(1, 0);
      @(posedge clk); #1; start_tx(0, 16'h0001, 1, 3, 1'b1); drain(0, 0);
      @(posedge clk); #1; start_tx(1, 16'h0000, 1, 2, 1'b0); drain(1, 0);

      // Loopback into a 4-bit 1101 detector.
      @(posedge clk); #1;
      start_tx(0, 16'h000D, 4, 3, 1'b0);
      drain(0, 0);
      chk_int("loop_det_count", det0.size(), 4);
      for (int i = 0; i < 4 && i < det0.size(); i++) chk_int("loop_det_cycle", det0[i], 4 * (i + 1));

      // No wrap on the repeat counter.
      @(posedge clk); #1; start_tx(1, 16'h0002, 2, 255, 1'b0); drain(1, 1);
      chk_int("rpt255_done_count", dn1.size(), 1);
      @(posedge clk); #1; start_tx(0, 16'hBEEF, 16, 255, 1'b0); drain(0, 1);

      // Randomized transactions with input noise while busy.
      for (int t = 0; t < 60; t++) begin
         int d, ln, rp;
         d  = $urandom_range(0, 1);
         ln = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 1) ? 0 : $urandom_range(WIDTH + 1, 31))
                                          : $urandom_range(1, WIDTH);
         rp = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 3);
         @(posedge clk); #1;
         start_tx(d, WIDTH'($urandom), ln, rp, $urandom_range(0, 1) == 1);
         drain(d, 1);
      end

      repeat (3) @(posedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
